// File: rtl/mem_arb_pkg.sv
// Shared types for the ic/dc memory port arbiter.
// State encoding, owner encoding and line geometry helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   localparam logic OWN_IC = 1'b0;
   localparam logic OWN_DC = 1'b1;

   function automatic int line_words(input int word_offset);
      return 1 << word_offset;
   endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker for the memory port arbiter.
// On a tie the requester that was not served last wins.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic [1:0] eligible,
   input  logic       last,
   output logic       gnt_valid,
   output logic       winner
);

   always_comb begin
      gnt_valid = |eligible;
      winner    = OWN_IC;
      unique case (1'b1)
         (eligible == 2'b11): winner = ~last;
         (eligible == 2'b10): winner = OWN_DC;
         (eligible == 2'b01): winner = OWN_IC;
         default:             winner = OWN_IC;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the ic and dc controllers.
// Sequences line refills and single-word write-throughs, one owner at a time.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADR_WIDTH   = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WORD_OFFSET = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_ic2arb,
   input  logic [ADR_WIDTH-1:0]   adr_ic2arb,
   input  logic                   rdwr_ic2arb,
   input  logic [DATA_WIDTH-1:0]  dat_ic2arb,
   input  logic                   req_dc2arb,
   input  logic [ADR_WIDTH-1:0]   adr_dc2arb,
   input  logic                   rdwr_dc2arb,
   input  logic [DATA_WIDTH-1:0]  dat_dc2arb,
   output logic                   ack_arb2ic,
   output logic                   ack_arb2dc,
   output logic [DATA_WIDTH-1:0]  dat_arb2cc,
   output logic [WORD_OFFSET-1:0] word_arb2cc,
   output logic                   req_arb2mem,
   output logic [ADR_WIDTH-1:0]   adr_arb2mem,
   output logic                   rdwr_arb2mem,
   output logic [DATA_WIDTH-1:0]  dat_arb2mem,
   input  logic                   ack_mem2arb,
   input  logic [DATA_WIDTH-1:0]  dat_mem2arb,
   output logic                   busy
);

   localparam int LINE_WORDS = line_words(WORD_OFFSET);
   localparam logic [WORD_OFFSET-1:0] LAST_WORD =
      WORD_OFFSET'(LINE_WORDS - 1);
   localparam int LINE_LSB = WORD_OFFSET + 2;

   arb_state_e             state_q, state_d;
   logic                   owner_q, owner_d;
   logic                   last_q, last_d;
   logic [1:0]             served_q, served_d;
   logic [WORD_OFFSET-1:0] cnt_q, cnt_d;
   logic                   req_q, req_d;
   logic                   rdwr_q, rdwr_d;
   logic [ADR_WIDTH-1:0]   adr_q, adr_d;
   logic [DATA_WIDTH-1:0]  dat_q, dat_d;

   logic                   in_busy;
   logic                   final_ack;
   logic [WORD_OFFSET-1:0] cnt_inc;
   logic [1:0]             eligible;
   logic                   gnt_valid;
   logic                   winner;
   logic [ADR_WIDTH-1:0]   sel_adr;
   logic                   sel_rdwr;
   logic [DATA_WIDTH-1:0]  sel_dat;

   assign in_busy   = (state_q == BUSY);
   assign cnt_inc   = cnt_q + 1'b1;
   assign final_ack = in_busy & ack_mem2arb &
                      (rdwr_q | (cnt_q == LAST_WORD));

   // A held req stays ineligible until it has been low for a cycle.
   assign eligible = {req_dc2arb & ~served_q[1],
                      req_ic2arb & ~served_q[0]};

   mem_arb_rr u_rr (
      .eligible  (eligible),
      .last      (last_q),
      .gnt_valid (gnt_valid),
      .winner    (winner)
   );

   assign sel_adr  = (winner == OWN_DC) ? adr_dc2arb  : adr_ic2arb;
   assign sel_rdwr = (winner == OWN_DC) ? rdwr_dc2arb : rdwr_ic2arb;
   assign sel_dat  = (winner == OWN_DC) ? dat_dc2arb  : dat_ic2arb;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      served_d = served_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      rdwr_d   = rdwr_q;
      adr_d    = adr_q;
      dat_d    = dat_q;

      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d = BUSY;
               owner_d = winner;
               last_d  = winner;
               cnt_d   = '0;
               req_d   = 1'b1;
               rdwr_d  = sel_rdwr;
               dat_d   = sel_dat;
               if (sel_rdwr) begin
                  adr_d = sel_adr;
               end else begin
                  adr_d = {sel_adr[ADR_WIDTH-1:LINE_LSB],
                           {WORD_OFFSET{1'b0}}, 2'b00};
               end
            end
         end
         BUSY: begin
            if (ack_mem2arb) begin
               cnt_d = cnt_inc;
               if (final_ack) begin
                  state_d = RELEASE;
                  req_d   = 1'b0;
               end else if (!rdwr_q) begin
                  adr_d = {adr_q[ADR_WIDTH-1:LINE_LSB],
                           cnt_inc, 2'b00};
               end
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (final_ack) begin
         served_d[owner_q] = 1'b1;
      end
      if (!req_ic2arb) begin
         served_d[0] = 1'b0;
      end
      if (!req_dc2arb) begin
         served_d[1] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= OWN_IC;
         last_q   <= OWN_IC;
         served_q <= '0;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         rdwr_q   <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         served_q <= served_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         rdwr_q   <= rdwr_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
      end
   end

   assign ack_arb2ic   = ack_mem2arb & in_busy & (owner_q == OWN_IC);
   assign ack_arb2dc   = ack_mem2arb & in_busy & (owner_q == OWN_DC);
   assign dat_arb2cc   = dat_mem2arb;
   assign word_arb2cc  = cnt_q;
   assign req_arb2mem  = req_q;
   assign adr_arb2mem  = adr_q;
   assign rdwr_arb2mem = rdwr_q;
   assign dat_arb2mem  = dat_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
// Expected per-word beats are queued at request time and popped on each ack.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic        req_ic2arb, req_dc2arb;
   logic [31:0] adr_ic2arb, adr_dc2arb;
   logic        rdwr_ic2arb, rdwr_dc2arb;
   logic [31:0] dat_ic2arb, dat_dc2arb;
   logic        ack_arb2ic, ack_arb2dc;
   logic [31:0] dat_arb2cc;
   logic [1:0]  word_arb2cc;
   logic        req_arb2mem;
   logic [31:0] adr_arb2mem;
   logic        rdwr_arb2mem;
   logic [31:0] dat_arb2mem;
   logic        ack_mem2arb;
   logic [31:0] dat_mem2arb;
   logic        busy;

   typedef struct {
      logic [31:0] adr;
      logic [1:0]  word;
      logic        owner;
      logic        rdwr;
      logic [31:0] dat;
   } beat_t;

   beat_t sb[$];
   int checks = 0;
   int errors = 0;

   mem_port_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_ic2arb   (req_ic2arb),
      .adr_ic2arb   (adr_ic2arb),
      .rdwr_ic2arb  (rdwr_ic2arb),
      .dat_ic2arb   (dat_ic2arb),
      .req_dc2arb   (req_dc2arb),
      .adr_dc2arb   (adr_dc2arb),
      .rdwr_dc2arb  (rdwr_dc2arb),
      .dat_dc2arb   (dat_dc2arb),
      .ack_arb2ic   (ack_arb2ic),
      .ack_arb2dc   (ack_arb2dc),
      .dat_arb2cc   (dat_arb2cc),
      .word_arb2cc  (word_arb2cc),
      .req_arb2mem  (req_arb2mem),
      .adr_arb2mem  (adr_arb2mem),
      .rdwr_arb2mem (rdwr_arb2mem),
      .dat_arb2mem  (dat_arb2mem),
      .ack_mem2arb  (ack_mem2arb),
      .dat_mem2arb  (dat_mem2arb),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_read(input logic own, input logic [31:0] adr,
                            input logic [31:0] dbase);
      for (int w = 0; w < 4; w++) begin
         beat_t b;
         b.adr   = {adr[31:4], 4'h0} + 32'(w * 4);
         b.word  = 2'(w);
         b.owner = own;
         b.rdwr  = 1'b0;
         b.dat   = dbase + 32'(w);
         sb.push_back(b);
      end
   endtask

   task automatic push_write(input logic own, input logic [31:0] adr);
      beat_t b;
      b.adr   = adr;
      b.word  = 2'd0;
      b.owner = own;
      b.rdwr  = 1'b1;
      b.dat   = 32'h0;
      sb.push_back(b);
   endtask

   // Memory model: n back-to-back acks, each checked against the queue.
   task automatic serve(input int n);
      for (int i = 0; i < n; i++) begin
         beat_t e;
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed 0 expected 1");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            ack_mem2arb = 1'b1;
            dat_mem2arb = e.dat;
            #1;
            chk("beat_adr", adr_arb2mem, e.adr);
            chk("beat_word", word_arb2cc, e.word);
            chk("beat_ack_ic", ack_arb2ic, e.owner == OWN_IC);
            chk("beat_ack_dc", ack_arb2dc, e.owner == OWN_DC);
            chk("beat_dat_cc", dat_arb2cc, e.dat);
            chk("beat_rdwr", rdwr_arb2mem, e.rdwr);
            chk("beat_req", req_arb2mem, 1'b1);
            tick();
         end
      end
      ack_mem2arb = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_ic2arb = 0; adr_ic2arb = 0; rdwr_ic2arb = 0; dat_ic2arb = 0;
      req_dc2arb = 0; adr_dc2arb = 0; rdwr_dc2arb = 0; dat_dc2arb = 0;
      ack_mem2arb = 0; dat_mem2arb = 0;
      tick();
      tick();
      chk("rst_req", req_arb2mem, 1'b0);
      chk("rst_adr", adr_arb2mem, 32'h0);
      chk("rst_rdwr", rdwr_arb2mem, 1'b0);
      chk("rst_dat", dat_arb2mem, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_word", word_arb2cc, 2'd0);
      rst = 1'b0;

      // ic line refill
      req_ic2arb = 1; adr_ic2arb = 32'hFF07BD08; rdwr_ic2arb = 0;
      push_read(OWN_IC, 32'hFF07BD08, 32'hFFFFFFFF);
      for (int i = 0; i < 4; i++) sb[i].dat = 32'hFFFFFFFF;
      tick();
      chk("ic_grant_req", req_arb2mem, 1'b1);
      chk("ic_grant_busy", busy, 1'b1);
      chk("ic_grant_adr", adr_arb2mem, 32'hFF07BD00);
      serve(4);
      chk("ic_rel_req", req_arb2mem, 1'b0);
      chk("ic_rel_busy", busy, 1'b1);
      req_ic2arb = 0;
      tick();
      chk("ic_idle_busy", busy, 1'b0);

      // simultaneous requests: dc wins the first tie
      req_ic2arb = 1; adr_ic2arb = 32'h00002004; rdwr_ic2arb = 0;
      req_dc2arb = 1; adr_dc2arb = 32'h0000310C; rdwr_dc2arb = 0;
      push_read(OWN_DC, 32'h0000310C, 32'h11110000);
      push_read(OWN_IC, 32'h00002004, 32'h22220000);
      tick();
      chk("tie_adr_dc", adr_arb2mem, 32'h00003100);
      serve(4);
      chk("tie_rel_req", req_arb2mem, 1'b0);
      tick();
      chk("tie_idle_req", req_arb2mem, 1'b0);
      tick();
      chk("tie_ic_req", req_arb2mem, 1'b1);
      chk("tie_ic_adr", adr_arb2mem, 32'h00002000);
      serve(4);
      tick();
      tick();
      tick();
      chk("served_no_regrant", req_arb2mem, 1'b0);
      chk("served_idle", busy, 1'b0);
      req_dc2arb = 0;
      tick();
      chk("pulse_low_req", req_arb2mem, 1'b0);
      req_dc2arb = 1;
      push_read(OWN_DC, 32'h0000310C, 32'h33330000);
      tick();
      chk("regrant_dc_req", req_arb2mem, 1'b1);
      chk("regrant_dc_adr", adr_arb2mem, 32'h00003100);
      serve(4);
      req_ic2arb = 0; req_dc2arb = 0;
      tick();
      tick();

      // dc write-through, then stray acks in RELEASE and IDLE
      req_dc2arb = 1; adr_dc2arb = 32'hFFFFFD08; rdwr_dc2arb = 1;
      dat_dc2arb = 32'hAA8AAAA4;
      push_write(OWN_DC, 32'hFFFFFD08);
      tick();
      chk("wr_req", req_arb2mem, 1'b1);
      chk("wr_adr", adr_arb2mem, 32'hFFFFFD08);
      chk("wr_rdwr", rdwr_arb2mem, 1'b1);
      chk("wr_dat", dat_arb2mem, 32'hAA8AAAA4);
      serve(1);
      chk("wr_rel_req", req_arb2mem, 1'b0);
      chk("wr_rel_busy", busy, 1'b1);
      req_dc2arb = 0;
      ack_mem2arb = 1; dat_mem2arb = 32'hDEADBEEF;
      #1;
      chk("stray_rel_ack_ic", ack_arb2ic, 1'b0);
      chk("stray_rel_ack_dc", ack_arb2dc, 1'b0);
      chk("stray_rel_word", word_arb2cc, 2'd1);
      tick();
      chk("stray_idle_ack_dc", ack_arb2dc, 1'b0);
      chk("stray_idle_busy", busy, 1'b0);
      chk("stray_idle_word", word_arb2cc, 2'd1);
      tick();
      chk("stray_idle2_word", word_arb2cc, 2'd1);
      chk("stray_idle2_req", req_arb2mem, 1'b0);
      ack_mem2arb = 0;

      // reset in the middle of an ic refill
      req_ic2arb = 1; adr_ic2arb = 32'h12345678; rdwr_ic2arb = 0;
      push_read(OWN_IC, 32'h12345678, 32'h44440000);
      tick();
      serve(2);
      chk("mid_adr", adr_arb2mem, 32'h12345678);
      rst = 1;
      tick();
      chk("mrst_req", req_arb2mem, 1'b0);
      chk("mrst_adr", adr_arb2mem, 32'h0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_word", word_arb2cc, 2'd0);
      chk("mrst_rdwr", rdwr_arb2mem, 1'b0);
      sb.delete();
      rst = 0;
      push_read(OWN_IC, 32'h12345678, 32'h55550000);
      tick();
      chk("mrst_regrant_req", req_arb2mem, 1'b1);
      chk("mrst_regrant_word", word_arb2cc, 2'd0);
      serve(4);
      req_ic2arb = 0;
      tick();
      tick();

      // owner drops req mid-burst; waiting dc gets the port after
      req_ic2arb = 1; adr_ic2arb = 32'hCAFE0010; rdwr_ic2arb = 0;
      push_read(OWN_IC, 32'hCAFE0010, 32'h66660000);
      tick();
      chk("drop_grant_adr", adr_arb2mem, 32'hCAFE0010);
      req_dc2arb = 1; adr_dc2arb = 32'h0000ABC4; rdwr_dc2arb = 1;
      dat_dc2arb = 32'h5A5A5A5A;
      push_write(OWN_DC, 32'h0000ABC4);
      serve(1);
      req_ic2arb = 0;
      serve(3);
      chk("drop_rel_req", req_arb2mem, 1'b0);
      tick();
      chk("drop_idle_req", req_arb2mem, 1'b0);
      tick();
      chk("drop_dc_req", req_arb2mem, 1'b1);
      chk("drop_dc_adr", adr_arb2mem, 32'h0000ABC4);
      chk("drop_dc_dat", dat_arb2mem, 32'h5A5A5A5A);
      serve(1);
      req_dc2arb = 0;
      tick();
      tick();
      chk("end_busy", busy, 1'b0);
      chk("end_sb_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
